// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : 32-iteration radix-2 restoring divider for MIPS div/divu that
//            produces {remainder, quotient} for the HILO register.
// Revision : 1.0  initial release
// ============================================================================
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        cancel,
    output logic        busy,
    output logic        ready,
    output logic [63:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] C_LAST_ITER = 5'd31;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvsr;
    logic        r_neg_q;
    logic        r_neg_r;

    logic        w_accept;
    logic [31:0] w_dvd_mag;
    logic [31:0] w_dvs_mag;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic [31:0] w_rem_nx;
    logic [31:0] w_quo_nx;
    logic [31:0] w_q_fin;
    logic [31:0] w_r_fin;

    // A start is only taken outside CALC, and a concurrent cancel kills it.
    assign w_accept  = start & ~cancel & (r_state != S_CALC);

    // 32-bit magnitudes: |0x8000_0000| stays 0x8000_0000 as an unsigned value.
    assign w_dvd_mag = (signed_div & dividend[31]) ? (~dividend + 32'd1) : dividend;
    assign w_dvs_mag = (signed_div & divisor[31])  ? (~divisor  + 32'd1) : divisor;

    assign w_shift   = {r_rem, r_quo[31]};
    assign w_diff    = w_shift - {1'b0, r_dvsr};
    assign w_rem_nx  = w_diff[32] ? w_shift[31:0] : w_diff[31:0];
    assign w_quo_nx  = {r_quo[30:0], ~w_diff[32]};

    assign w_q_fin   = r_neg_q ? (~w_quo_nx + 32'd1) : w_quo_nx;
    assign w_r_fin   = r_neg_r ? (~w_rem_nx + 32'd1) : w_rem_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_rem   <= 32'd0;
            r_quo   <= 32'd0;
            r_dvsr  <= 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            busy    <= 1'b0;
            ready   <= 1'b0;
            result  <= 64'd0;
        end else begin
            ready <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept && (divisor == 32'd0)) begin
                        result  <= {dividend, 32'hFFFF_FFFF};
                        ready   <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_accept) begin
                        r_rem   <= 32'd0;
                        r_quo   <= w_dvd_mag;
                        r_dvsr  <= w_dvs_mag;
                        r_neg_q <= signed_div & (dividend[31] ^ divisor[31]);
                        r_neg_r <= signed_div & dividend[31];
                        r_cnt   <= 5'd0;
                        busy    <= 1'b1;
                        r_state <= S_CALC;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        r_cnt   <= 5'd0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == C_LAST_ITER) begin
                            result  <= {w_r_fin, w_q_fin};
                            ready   <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_DONE;
                        end
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Directed-vector bench for div_unit with an arithmetic reference
//            model checked every cycle plus hand-computed literal results.
// Revision : 1.0  initial release
// ============================================================================
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        cancel = 1'b0;
    logic        busy;
    logic        ready;
    logic [63:0] result;

    int checks = 0;
    int passes = 0;

    div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .cancel     (cancel),
        .busy       (busy),
        .ready      (ready),
        .result     (result)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference arithmetic: 64-bit signed division truncates toward zero and
    // cannot overflow for 32-bit operands.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Timeline model: a division occupies 32 busy cycles, then one ready cycle.
    int          m_left = 0;
    logic [63:0] m_pend = 64'd0;
    logic        exp_busy = 1'b0;
    logic        exp_ready = 1'b0;
    logic [63:0] exp_result = 64'd0;
    bit          cmp_en = 1'b0;

    always @(posedge clk) begin
        exp_ready = 1'b0;
        if (rst) begin
            m_left = 0;
            exp_busy = 1'b0;
            exp_result = 64'd0;
        end else if (m_left > 0) begin
            if (cancel) begin
                m_left = 0;
                exp_busy = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    exp_busy = 1'b0;
                    exp_ready = 1'b1;
                    exp_result = m_pend;
                end
            end
        end else if (start && !cancel) begin
            if (divisor == 32'd0) begin
                exp_ready = 1'b1;
                exp_result = {dividend, 32'hFFFF_FFFF};
            end else begin
                m_left = 32;
                exp_busy = 1'b1;
                m_pend = ref_div(dividend, divisor, signed_div);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check(busy == exp_busy, "busy", {63'd0, busy}, {63'd0, exp_busy});
            check(ready == exp_ready, "ready", {63'd0, ready}, {63'd0, exp_ready});
            check(result == exp_result, "result", result, exp_result);
        end
    end

    // Issue one start; return cycles until ready (0 if none within bound).
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output int lat, output int busy_cycles);
        @(negedge clk);
        start = 1'b1; signed_div = s; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_cycles = 0;
        for (int n = 1; n <= 100; n++) begin
            if (busy) busy_cycles++;
            if (ready) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic div_expect(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic s, input logic [63:0] exp, input int exp_lat);
        int lat, bc;
        run_div(a, b, s, lat, bc);
        check(lat == exp_lat, {name, " latency"}, 64'(lat), 64'(exp_lat));
        check(result == exp, {name, " value"}, result, exp);
        check(bc == ((exp_lat == 1) ? 0 : 32), {name, " busy cycles"}, 64'(bc),
              64'((exp_lat == 1) ? 0 : 32));
    endtask

    task automatic cancel_case(input string name, input bit with_start, input logic [63:0] keep);
        bit saw_ready;
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        start = with_start;
        @(negedge clk);
        cancel = 1'b0;
        start = 1'b0;
        check(busy == 1'b0, {name, " busy after cancel"}, {63'd0, busy}, 64'd0);
        saw_ready = 1'b0;
        repeat (40) begin
            if (ready || busy) saw_ready = 1'b1;
            @(negedge clk);
        end
        check(!saw_ready, {name, " no activity"}, {63'd0, saw_ready}, 64'd0);
        check(result == keep, {name, " result held"}, result, keep);
    endtask

    initial begin
        int lat1, lat2, bc;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        check(busy == 1'b0 && ready == 1'b0 && result == 64'd0, "reset state",
              {busy, ready, result[61:0]}, 64'd0);

        div_expect("u100/7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);
        div_expect("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        div_expect("s7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
        div_expect("smin/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 33);
        div_expect("umax/1", 32'hFFFF_FFFF, 32'd1, 1'b0, {32'h0, 32'hFFFF_FFFF}, 33);
        div_expect("u-7/2", 32'hFFFF_FFF9, 32'd2, 1'b0, {32'd1, 32'h7FFF_FFFC}, 33);
        div_expect("div0", 32'h1234_5678, 32'd0, 1'b1, {32'h1234_5678, 32'hFFFF_FFFF}, 1);

        cancel_case("cancel", 1'b0, {32'h1234_5678, 32'hFFFF_FFFF});
        cancel_case("cancel+start", 1'b1, {32'h1234_5678, 32'hFFFF_FFFF});

        // Reset mid-CALC at cycle 20.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check(busy == 1'b0 && ready == 1'b0 && result == 64'd0, "reset mid-calc",
              {busy, ready, result[61:0]}, 64'd0);

        // Back-to-back: second start issued in the first's DONE cycle.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; dividend = 32'd50; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0;
        lat1 = 0; lat2 = 0; bc = 0;
        for (int n = 1; n <= 100; n++) begin
            if (ready && lat1 == 0) begin
                lat1 = n;
                check(result == {32'd0, 32'd10}, "b2b first value", result, {32'd0, 32'd10});
                start = 1'b1; dividend = 32'd9; divisor = 32'd4;
            end else if (ready) begin
                lat2 = n;
                check(result == {32'd1, 32'd2}, "b2b second value", result, {32'd1, 32'd2});
                break;
            end else begin
                start = 1'b0;
            end
            if (busy) bc++;
            @(negedge clk);
        end
        start = 1'b0;
        check(lat1 == 33, "b2b first latency", 64'(lat1), 64'd33);
        check(lat2 == 66, "b2b second latency", 64'(lat2), 64'd66);
        check(bc == 64, "b2b busy cycles", 64'(bc), 64'd64);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
